// File: rtl/fpga_input_conditioner_if.sv
// Board-side button/restart bundle for the input conditioner.
// master = board/test side, slave = conditioner.
interface fpga_input_conditioner_if;
    logic [3:0] i_btn;
    logic       i_restart;
    logic [3:0] o_btn;
    logic [3:0] o_press;
    logic       o_restart;

    modport master (
        output i_btn, i_restart,
        input  o_btn, o_press, o_restart
    );

    modport slave (
        input  i_btn, i_restart,
        output o_btn, o_press, o_restart
    );
endinterface

// File: rtl/fpga_input_conditioner.sv
// Sync + debounce of 4 buttons and restart switch, with press pulses.
// Optional auto-repeat of press pulses: define INPUT_AUTOREPEAT_EN.
module fpga_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 252000,
    parameter int REPEAT_DELAY    = 12587500,
    parameter int REPEAT_PERIOD   = 2517500
) (
    input logic                      clk,
    input logic                      rst_n,
    fpga_input_conditioner_if.slave  io
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2) begin : g_chk_db
        $error("DEBOUNCE_CYCLES must be >= 2");
    end
    if (REPEAT_PERIOD < 1 || REPEAT_PERIOD > REPEAT_DELAY) begin : g_chk_rp
        $error("REPEAT_PERIOD must be in 1..REPEAT_DELAY");
    end

    logic [4:0]    raw;
    logic [4:0]    q1;
    logic [4:0]    s;
    logic [4:0]    d;
    logic [CW-1:0] cnt [5];
    logic [4:0]    rise;
    logic [4:0]    fall;
    logic [3:0]    press;

    assign raw = {io.i_restart, io.i_btn};

    always_comb begin
        rise = '0;
        fall = '0;
        for (int i = 0; i < 5; i++) begin
            rise[i] = s[i] & ~d[i] & (cnt[i] == CMAX);
            fall[i] = ~s[i] & d[i] & (cnt[i] == CMAX);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q1 <= '0;
            s  <= '0;
            d  <= '0;
            for (int i = 0; i < 5; i++) cnt[i] <= '0;
        end else begin
            q1 <= raw;
            s  <= q1;
            for (int i = 0; i < 5; i++) begin
                if (s[i] == d[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] != CMAX) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end else begin
                    d[i]   <= s[i];
                    cnt[i] <= '0;
                end
            end
        end
    end

`ifdef INPUT_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_DELAY + 1);
    localparam logic [RW-1:0] RTOP  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RLOAD = RW'(REPEAT_DELAY - REPEAT_PERIOD);

    logic [RW-1:0] rc [4];

    // A release on the same edge as a due repeat wins: no pulse fires.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            press <= '0;
            for (int i = 0; i < 4; i++) rc[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                press[i] <= rise[i];
                if (rise[i] || fall[i]) begin
                    rc[i] <= '0;
                end else if (d[i]) begin
                    if (rc[i] == RTOP) begin
                        press[i] <= 1'b1;
                        rc[i]    <= RLOAD;
                    end else begin
                        rc[i] <= rc[i] + 1'b1;
                    end
                end
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (!rst_n) press <= '0;
        else        press <= rise[3:0];
    end
`endif

    assign io.o_btn     = d[3:0];
    assign io.o_restart = d[4];
    assign io.o_press   = press;

endmodule
